// File: rtl/code_seq_pkg.sv
// Shared code-sequence definitions: the 10-entry index-to-code table used by
// the sequence generator and by the downstream decoder's bench.
package code_seq_pkg;

  localparam int NUM_CODES = 10;

  typedef logic [3:0] code_t;

  localparam code_t CODE_TABLE [NUM_CODES] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111,
    4'b0110, 4'b0100, 4'b0101, 4'b1111, 4'b1110
  };

  // Index to code lookup; out-of-range indices map to code 0000.
  function automatic code_t idx2code(input logic [3:0] idx);
    code_t c;
    c = '0;
    for (int k = 0; k < NUM_CODES; k++)
      if (idx == 4'(k)) c = CODE_TABLE[k];
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchroniser, stable-count debouncer and a
// one-cycle pulse on the rising edge of the debounced level.
module btn_debounce
  import code_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_sync;
  logic          r_db, r_db_d;
  logic [CW-1:0] r_cnt;

  // Two-stage synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_s1   <= i_btn;
      r_sync <= r_s1;
    end
  end

  // Accept a new level only after it has differed from db for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
    end else begin
      r_db_d <= r_db;
      if (r_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_db  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/code_seq_gen.sv
// Code sequence generator: steps a 0..9 position by debounced up/down buttons
// or an auto-step tick, and drives the matching decoder code.
module code_seq_gen
  import code_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       run_i,
  output logic [3:0] code_o,
  output logic [3:0] index_o,
  output logic       step_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic          w_press_up, w_press_dn;
  logic          r_run_s1, r_run_sync;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_up_req, w_dn_req, w_step;
  logic [3:0]    w_idx_nxt;
  logic [3:0]    r_index;
  code_t         r_code;
  logic          r_step;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_up_i),
    .o_press (w_press_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_down_i),
    .o_press (w_press_dn)
  );

  // Synchronise run enable; no debounce, it is a level control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_s1   <= 1'b0;
      r_run_sync <= 1'b0;
    end else begin
      r_run_s1   <= run_i;
      r_run_sync <= r_run_s1;
    end
  end

  assign w_tick = r_run_sync && (r_tick_cnt == TICK_MAX);

  // Free-running auto-step divider, held at zero while run is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_tick_cnt <= '0;
    else if (!r_run_sync) r_tick_cnt <= '0;
    else if (w_tick)      r_tick_cnt <= '0;
    else                  r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Arbitrate: a tick merges with a manual up; opposing requests cancel.
  always_comb begin
    w_up_req  = w_press_up | w_tick;
    w_dn_req  = w_press_dn;
    w_step    = w_up_req ^ w_dn_req;
    w_idx_nxt = r_index;
    if (w_up_req && !w_dn_req)
      w_idx_nxt = (r_index == 4'd9) ? 4'd0 : r_index + 4'd1;
    else if (w_dn_req && !w_up_req)
      w_idx_nxt = (r_index == 4'd0) ? 4'd9 : r_index - 4'd1;
  end

  // Index, code and step strobe all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 4'd0;
      r_code  <= 4'b0000;
      r_step  <= 1'b0;
    end else begin
      r_index <= w_idx_nxt;
      r_code  <= idx2code(w_idx_nxt);
      r_step  <= w_step;
    end
  end

  assign code_o  = r_code;
  assign index_o = r_index;
  assign step_o  = r_step;

endmodule

// File: tb/tb_code_seq_gen.sv
// Directed bench for code_seq_gen with DEBOUNCE_CYCLES=4, TICK_DIV=8.
module tb_code_seq_gen;
  import code_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic       run_i = 1'b0;
  logic [3:0] code_o, index_o;
  logic       step_o;

  int vecs = 0;
  int errs = 0;
  int steps = 0;

  code_seq_gen #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_i   (btn_up_i),
    .btn_down_i (btn_down_i),
    .run_i      (run_i),
    .code_o     (code_o),
    .index_o    (index_o),
    .step_o     (step_o)
  );

  always #5 clk = ~clk;

  // Count step pulses away from the active edge.
  always @(negedge clk) if (rst_n && step_o) steps++;

  task automatic check(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return just after the following falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic press_up();
    btn_up_i = 1'b1; cyc(8);
    btn_up_i = 1'b0; cyc(8);
  endtask

  task automatic press_dn();
    btn_down_i = 1'b1; cyc(8);
    btn_down_i = 1'b0; cyc(8);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int s0;
  logic [3:0] exp_codes [11];

  initial begin
    exp_codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0110,
                  4'b0100, 4'b0101, 4'b1111, 4'b1110, 4'b0000};

    // Power-on reset
    cyc(2);
    check("por_code", code_o, 0);
    check("por_index", index_o, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1. Async reset mid-operation
    press_up(); press_up(); press_up();
    check("pre_rst_index", index_o, 3);
    check("pre_rst_code", code_o, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rst_code", code_o, 0);
    check("rst_index", index_o, 0);
    check("rst_step", step_o, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 2. Clean press: update exactly on edge 6
    s0 = steps;
    btn_up_i = 1'b1;
    cyc(6);
    check("clean_e5_index", index_o, 0);
    cyc(1);
    check("clean_e6_index", index_o, 1);
    check("clean_e6_code", code_o, 4'b0001);
    check("clean_e6_step", step_o, 1);
    cyc(13);
    btn_up_i = 1'b0;
    cyc(12);
    check("clean_one_step", steps - s0, 1);
    check("clean_hold_index", index_o, 1);

    // 3. Bounce then settle high
    s0 = steps;
    for (int i = 0; i < 10; i++) begin
      btn_up_i = ~i[0];
      cyc(1);
    end
    btn_up_i = 1'b1;
    cyc(6);
    check("bounce_e5_index", index_o, 1);
    cyc(1);
    check("bounce_e6_index", index_o, 2);
    check("bounce_e6_step", step_o, 1);
    cyc(10);
    btn_up_i = 1'b0;
    cyc(10);
    check("bounce_one_step", steps - s0, 1);

    // 4. Wrap down from 0, then walk ten up presses
    do_reset();
    press_dn();
    check("wrap_dn_index", index_o, 9);
    check("wrap_dn_code", code_o, 4'b1110);
    press_up();
    check("wrap_up_index", index_o, 0);
    s0 = steps;
    for (int i = 1; i <= 10; i++) begin
      press_up();
      check("walk_code", code_o, exp_codes[i]);
    end
    check("walk_steps", steps - s0, 10);
    check("walk_index", index_o, 0);

    // 5. Auto-step for 43 cycles
    do_reset();
    s0 = steps;
    run_i = 1'b1;
    cyc(9);
    check("run_e8_index", index_o, 0);
    cyc(1);
    check("run_e9_step", step_o, 1);
    check("run_e9_index", index_o, 1);
    cyc(33);
    run_i = 1'b0;
    cyc(10);
    check("run_steps", steps - s0, 5);
    check("run_index", index_o, 5);
    check("run_code", code_o, 4'b0110);
    check("run_tick_cnt", dut.r_tick_cnt, 0);

    // 6a. Simultaneous up and down presses cancel
    do_reset();
    s0 = steps;
    btn_up_i = 1'b1; btn_down_i = 1'b1;
    cyc(12);
    btn_up_i = 1'b0; btn_down_i = 1'b0;
    cyc(10);
    check("conflict_steps", steps - s0, 0);
    check("conflict_index", index_o, 0);

    // 6b. Up press coinciding with a tick gives one step
    s0 = steps;
    run_i = 1'b1;
    cyc(3);
    btn_up_i = 1'b1;
    cyc(7);
    check("align_step", step_o, 1);
    check("align_index", index_o, 1);
    cyc(2);
    run_i = 1'b0;
    cyc(6);
    btn_up_i = 1'b0;
    cyc(10);
    check("align_steps", steps - s0, 1);
    check("align_final_index", index_o, 1);
    check("align_final_code", code_o, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
